// File: rtl/prim_esc_sender.sv
`default_nettype none
// ============================================================================
// Module   : prim_esc_sender
// Brief    : Differential escalation sender with ping handshake and response
//            integrity checking against a toggling receiver.
// Revision : 1.0 - initial release
// ============================================================================

module prim_esc_sender #(
    parameter int PING_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ping_req_i,
    input  logic       esc_req_i,
    input  logic [1:0] esc_rx_i,
    output logic [1:0] esc_tx_o,
    output logic       ping_ok_o,
    output logic       integ_fail_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PING_PULSE = 3'd1,
        ST_PING_CHK   = 3'd2,
        ST_ESC_WAIT   = 3'd3,
        ST_ESC_CHK    = 3'd4,
        ST_ESC_DRAIN  = 3'd5
    } state_t;

    localparam logic [1:0] c_tx_idle   = 2'b01;
    localparam logic [1:0] c_tx_active = 2'b10;
    localparam logic [3:0] c_last_cnt  = 4'(PING_LEN - 1);

    state_t     r_state;
    logic [1:0] r_esc_tx;
    logic       r_ping_ok;
    logic       r_integ_fail;
    logic [3:0] r_cnt;
    logic       r_phase;

    logic [1:0] w_exp_rx;
    logic       w_checked;
    logic       w_rx_bad;

    // Only the toggling check states expect the phase pattern; all other
    // checked states expect the receiver to sit at its idle level.
    always_comb begin
        w_exp_rx = c_tx_idle;
        if ((r_state == ST_PING_CHK) || (r_state == ST_ESC_CHK)) begin
            w_exp_rx = {r_phase, ~r_phase};
        end
    end

    assign w_checked = (r_state != ST_ESC_DRAIN);
    assign w_rx_bad  = (esc_rx_i != w_exp_rx) || (esc_rx_i[1] == esc_rx_i[0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_esc_tx     <= c_tx_idle;
            r_ping_ok    <= 1'b0;
            r_integ_fail <= 1'b0;
            r_cnt        <= 4'd0;
            r_phase      <= 1'b1;
        end else begin
            r_ping_ok    <= 1'b0;
            r_integ_fail <= w_checked && w_rx_bad;

            case (r_state)
                ST_IDLE: begin
                    if (esc_req_i) begin
                        r_state  <= ST_ESC_WAIT;
                        r_esc_tx <= c_tx_active;
                    end else if (ping_req_i) begin
                        r_state  <= ST_PING_PULSE;
                        r_esc_tx <= c_tx_active;
                    end else begin
                        r_esc_tx <= c_tx_idle;
                    end
                end

                ST_PING_PULSE: begin
                    r_esc_tx <= c_tx_idle;
                    if (esc_req_i) begin
                        // An escalation proves the path as well as a ping would.
                        r_ping_ok <= 1'b1;
                        r_state   <= ST_ESC_WAIT;
                        r_esc_tx  <= c_tx_active;
                    end else if (w_rx_bad) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_PING_CHK;
                        r_cnt   <= 4'd0;
                        r_phase <= 1'b1;
                    end
                end

                ST_PING_CHK: begin
                    r_esc_tx <= c_tx_idle;
                    if (esc_req_i) begin
                        r_ping_ok <= 1'b1;
                        r_state   <= ST_ESC_WAIT;
                        r_esc_tx  <= c_tx_active;
                    end else if (w_rx_bad) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_last_cnt) begin
                        r_ping_ok <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_phase <= ~r_phase;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end

                ST_ESC_WAIT: begin
                    r_ping_ok <= ping_req_i;
                    if (esc_req_i) begin
                        r_state  <= ST_ESC_CHK;
                        r_phase  <= 1'b1;
                        r_esc_tx <= c_tx_active;
                    end else begin
                        r_state  <= ST_ESC_DRAIN;
                        r_esc_tx <= c_tx_idle;
                    end
                end

                ST_ESC_CHK: begin
                    // Phase advances regardless of the check result so one bad
                    // response does not desynchronise the rest of the escalation.
                    r_ping_ok <= ping_req_i;
                    r_phase   <= ~r_phase;
                    if (esc_req_i) begin
                        r_esc_tx <= c_tx_active;
                    end else begin
                        r_state  <= ST_ESC_DRAIN;
                        r_esc_tx <= c_tx_idle;
                    end
                end

                ST_ESC_DRAIN: begin
                    if (esc_req_i) begin
                        r_state  <= ST_ESC_WAIT;
                        r_esc_tx <= c_tx_active;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_esc_tx <= c_tx_idle;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_esc_tx <= c_tx_idle;
                end
            endcase
        end
    end

    assign esc_tx_o     = r_esc_tx;
    assign ping_ok_o    = r_ping_ok;
    assign integ_fail_o = r_integ_fail;

endmodule

`default_nettype wire

// File: tb/tb_prim_esc_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_esc_sender
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_prim_esc_sender;

    localparam int PING_LEN = 4;

    logic       clk;
    logic       rst_i;
    logic       ping_req_i;
    logic       esc_req_i;
    logic [1:0] esc_rx_i;
    logic [1:0] esc_tx_o;
    logic       ping_ok_o;
    logic       integ_fail_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 ping, 2 escalation, 3 drain. m_idx counts response
    // slots since the ping/escalation began; slot 0 expects 01, then odd
    // slots expect 10 and even slots 01.
    int         m_mode = 0;
    int         m_idx  = 0;
    logic [1:0] m_tx   = 2'b01;
    logic       m_ok   = 1'b0;
    logic       m_fail = 1'b0;
    bit         esc_lvl = 1'b0;

    prim_esc_sender #(.PING_LEN(PING_LEN)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ping_req_i   (ping_req_i),
        .esc_req_i    (esc_req_i),
        .esc_rx_i     (esc_rx_i),
        .esc_tx_o     (esc_tx_o),
        .ping_ok_o    (ping_ok_o),
        .integ_fail_o (integ_fail_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] slot_exp(input int idx);
        if (idx == 0) return 2'b01;
        return (idx % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] model_exp_rx();
        if (m_mode == 1 || m_mode == 2) return slot_exp(m_idx);
        return 2'b01;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit e, input logic [1:0] rx);
        bit bad;
        bad = (rx != model_exp_rx()) || (rx[1] == rx[0]);
        m_ok   = 1'b0;
        m_fail = 1'b0;
        if (r) begin
            m_mode = 0;
            m_idx  = 0;
            m_tx   = 2'b01;
            return;
        end
        case (m_mode)
            0: begin
                m_fail = bad;
                m_idx  = 0;
                if (e)      begin m_mode = 2; m_tx = 2'b10; end
                else if (p) begin m_mode = 1; m_tx = 2'b10; end
                else        m_tx = 2'b01;
            end
            1: begin
                m_fail = bad;
                m_tx   = 2'b01;
                if (e) begin
                    m_ok = 1'b1; m_mode = 2; m_idx = 0; m_tx = 2'b10;
                end else if (bad) begin
                    m_mode = 0;
                end else if (m_idx == PING_LEN) begin
                    m_ok = 1'b1; m_mode = 0;
                end else begin
                    m_idx++;
                end
            end
            2: begin
                m_fail = bad;
                m_ok   = p;
                if (e) begin m_tx = 2'b10; m_idx++; end
                else   begin m_tx = 2'b01; m_mode = 3; end
            end
            default: begin
                if (e) begin m_mode = 2; m_idx = 0; m_tx = 2'b10; end
                else   begin m_mode = 0; m_tx = 2'b01; end
            end
        endcase
    endtask

    // One clock: check outputs of the previous edge, then apply inputs for the
    // next edge. frc replaces the well-behaved receiver response with frx.
    task automatic cyc(input bit r, input bit p, input bit e, input bit frc, input logic [1:0] frx);
        @(negedge clk);
        chk("esc_tx",     esc_tx_o,            m_tx);
        chk("ping_ok",    {1'b0, ping_ok_o},    {1'b0, m_ok});
        chk("integ_fail", {1'b0, integ_fail_o}, {1'b0, m_fail});
        rst_i      = r;
        ping_req_i = p;
        esc_req_i  = e;
        esc_rx_i   = frc ? frx : model_exp_rx();
        model_step(r, p, e, esc_rx_i);
    endtask

    initial begin
        rst_i      = 1'b1;
        ping_req_i = 1'b0;
        esc_req_i  = 1'b0;
        esc_rx_i   = 2'b01;
        model_step(1'b1, 1'b0, 1'b0, 2'b01);

        cyc(1, 0, 0, 0, 2'b00);
        repeat (3) cyc(0, 0, 0, 0, 2'b00);

        // Clean ping
        cyc(0, 1, 0, 0, 2'b00);
        repeat (8) cyc(0, 0, 0, 0, 2'b00);

        // Ping with a bad response in the middle of the check window
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 2'b01);
        repeat (4) cyc(0, 0, 0, 0, 2'b00);

        // Escalation with a ping and one stuck response
        for (int i = 0; i < 10; i++)
            cyc(0, i == 4, 1, i == 6, 2'b11);
        repeat (3) cyc(0, 0, 0, 0, 2'b00);

        // Escalation preempting a ping
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 2'b00);
        repeat (4) cyc(0, 0, 1, 0, 2'b00);
        repeat (3) cyc(0, 0, 0, 0, 2'b00);

        // Reset in the middle of escalation
        repeat (5) cyc(0, 0, 1, 0, 2'b00);
        cyc(1, 0, 1, 0, 2'b00);
        repeat (4) cyc(0, 0, 0, 0, 2'b00);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) esc_lvl = ~esc_lvl;
            cyc($urandom_range(0, 149) == 0,
                $urandom_range(0, 5) == 0,
                esc_lvl,
                $urandom_range(0, 11) == 0,
                2'($urandom_range(0, 3)));
        end
        cyc(0, 0, 0, 0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
